// File: rtl/bcd_xs3_converter.sv
// Multi-digit BCD <-> Excess-3 converter, one digit per cycle, valid/ready on both sides.
// Invalid input digits produce 4'hF and set the matching out_err bit.
module bcd_xs3_converter #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [4*DIGITS-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_data,
    output logic [DIGITS-1:0]   out_err,
    output logic                out_mode
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [4*DIGITS-1:0] src_q;
    logic [4*DIGITS-1:0] res_q;
    logic [DIGITS-1:0]   err_q;
    logic                mode_q;
    logic [3:0]          nib_d;
    logic                bad_d;

    // Returns {error, nibble}; mode 0 is BCD->XS3, mode 1 is XS3->BCD.
    function automatic logic [4:0] convert_digit(input logic [3:0] d, input logic mode);
        logic [4:0] r;
        if (!mode) begin
            r = (d <= 4'd9) ? {1'b0, d + 4'd3} : {1'b1, 4'hF};
        end else begin
            r = (d >= 4'd3 && d <= 4'd12) ? {1'b0, d - 4'd3} : {1'b1, 4'hF};
        end
        return r;
    endfunction

    always_comb begin
        {bad_d, nib_d} = convert_digit(src_q[{idx_q, 2'b00} +: 4], mode_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            res_q   <= '0;
            err_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        src_q   <= in_data;
                        mode_q  <= in_mode;
                        res_q   <= '0;
                        err_q   <= '0;
                        idx_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    res_q[{idx_q, 2'b00} +: 4] <= nib_d;
                    err_q[idx_q]               <= bad_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags come from registered state; rst only masks them.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE) && !rst;
    assign out_data  = res_q;
    assign out_err   = err_q;
    assign out_mode  = mode_q;

endmodule

// File: tb/tb_bcd_xs3_converter.sv
// Directed bench for bcd_xs3_converter: a DIGITS=4 instance and a DIGITS=1 instance.
module tb_bcd_xs3_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, iv4, ir4, im4, ov4, or4, om4;
    logic [15:0] id4, od4;
    logic [3:0]  oe4;

    logic        rst1, iv1, ir1, im1, ov1, or1, om1;
    logic [3:0]  id1, od1;
    logic [0:0]  oe1;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_xs3_converter #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst4),
        .in_valid(iv4), .in_ready(ir4), .in_mode(im4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_err(oe4), .out_mode(om4)
    );

    bcd_xs3_converter #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst1),
        .in_valid(iv1), .in_ready(ir1), .in_mode(im1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_err(oe1), .out_mode(om1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer4(input logic m, input logic [15:0] d, input logic [15:0] ed,
                         input logic [3:0] ee, input string tag);
        int lat;
        check({tag, "/in_ready"}, 32'(ir4), 32'd1);
        iv4 = 1'b1; im4 = m; id4 = d;
        tick;
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 20) begin
            tick;
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'd5);
        check({tag, "/data"}, 32'(od4), 32'(ed));
        check({tag, "/err"}, 32'(oe4), 32'(ee));
        check({tag, "/mode"}, 32'(om4), 32'(m));
        tick;
        check({tag, "/valid_1cyc"}, 32'(ov4), 32'd0);
        check({tag, "/ready_back"}, 32'(ir4), 32'd1);
    endtask

    task automatic xfer1(input logic m, input logic [3:0] d, input logic [3:0] ed,
                         input logic ee, input string tag);
        int lat;
        check({tag, "/in_ready"}, 32'(ir1), 32'd1);
        iv1 = 1'b1; im1 = m; id1 = d;
        tick;
        iv1 = 1'b0;
        lat = 1;
        while (!ov1 && lat < 20) begin
            tick;
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'd2);
        check({tag, "/data"}, 32'(od1), 32'(ed));
        check({tag, "/err"}, 32'(oe1), 32'(ee));
        check({tag, "/mode"}, 32'(om1), 32'(m));
        tick;
        check({tag, "/valid_1cyc"}, 32'(ov1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  seen;
        rst4 = 1'b1; iv4 = 1'b0; im4 = 1'b0; id4 = '0; or4 = 1'b1;
        rst1 = 1'b1; iv1 = 1'b0; im1 = 1'b0; id1 = '0; or1 = 1'b1;
        tick;
        tick;
        check("rst/in_ready_low", 32'(ir4), 32'd0);
        check("rst/out_valid_low", 32'(ov4), 32'd0);
        rst4 = 1'b0; rst1 = 1'b0;
        tick;
        check("post_rst/in_ready", 32'(ir4), 32'd1);
        check("post_rst/out_valid", 32'(ov4), 32'd0);
        check("post_rst/data", 32'(od4), 32'd0);
        check("post_rst/err", 32'(oe4), 32'd0);
        check("post_rst/mode", 32'(om4), 32'd0);

        xfer4(1'b0, 16'h1234, 16'h4567, 4'b0000, "b2x_1234");
        xfer4(1'b1, 16'h4567, 16'h1234, 4'b0000, "x2b_4567");
        xfer4(1'b0, 16'h9999, 16'hCCCC, 4'b0000, "b2x_9999");
        xfer4(1'b0, 16'h9A05, 16'hCF38, 4'b0100, "b2x_9A05");
        xfer4(1'b1, 16'h3C2D, 16'h09FF, 4'b0011, "x2b_3C2D");

        // Backpressure in DONE with a competing word on the input.
        or4 = 1'b0;
        iv4 = 1'b1; im4 = 1'b0; id4 = 16'h1234;
        tick;
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 20) begin
            tick;
            lat++;
        end
        check("bp/latency", 32'(lat), 32'd5);
        iv4 = 1'b1; im4 = 1'b1; id4 = 16'h5555;
        for (int i = 0; i < 6; i++) begin
            check("bp/out_valid_held", 32'(ov4), 32'd1);
            check("bp/in_ready_low", 32'(ir4), 32'd0);
            check("bp/data_frozen", 32'(od4), 32'h4567);
            check("bp/mode_frozen", 32'(om4), 32'd0);
            tick;
        end
        check("bp/still_valid", 32'(ov4), 32'd1);
        or4 = 1'b1;
        tick;
        check("bp/handshake_valid", 32'(ov4), 32'd0);
        check("bp/handshake_ready", 32'(ir4), 32'd1);
        tick;
        check("bp/accepted", 32'(ir4), 32'd0);
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 20) begin
            tick;
            lat++;
        end
        check("bp2/latency", 32'(lat), 32'd5);
        check("bp2/data", 32'(od4), 32'h2222);
        check("bp2/err", 32'(oe4), 32'd0);
        check("bp2/mode", 32'(om4), 32'd1);
        tick;

        // Abort a mode-1 word with reset while idx=2.
        iv4 = 1'b1; im4 = 1'b1; id4 = 16'h4567;
        tick;
        iv4 = 1'b0;
        tick;
        tick;
        rst4 = 1'b1;
        #1;
        check("abort/in_ready_in_rst", 32'(ir4), 32'd0);
        check("abort/out_valid_in_rst", 32'(ov4), 32'd0);
        tick;
        rst4 = 1'b0;
        #1;
        check("abort/in_ready", 32'(ir4), 32'd1);
        check("abort/data", 32'(od4), 32'd0);
        check("abort/err", 32'(oe4), 32'd0);
        check("abort/mode", 32'(om4), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (ov4) seen = 1'b1;
        end
        check("abort/no_out_valid", 32'(seen), 32'd0);
        xfer4(1'b0, 16'h0000, 16'h3333, 4'b0000, "b2x_0000");

        check("d1/post_rst_ready", 32'(ir1), 32'd1);
        xfer1(1'b0, 4'h7, 4'hA, 1'b0, "d1_b2x_7");
        xfer1(1'b1, 4'h2, 4'hF, 1'b1, "d1_x2b_2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_xs3_converter.md
# bcd_xs3_converter

Multi-digit, bidirectional BCD/Excess-3 code converter with valid/ready handshakes on both sides. It accepts one packed word of `DIGITS` nibbles, converts it one digit per cycle in either direction, flags each invalid input digit, and holds the result until the consumer takes it. It sits between the BCD arithmetic datapath and the XS3 display/serial stages, and is the sequential, parametrised successor to the single-digit combinational converter.

## Interface
- `DIGITS`, default 4: number of 4-bit digits per word; legal range 1–16.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: producer has a word on `in_data`/`in_mode`.
- `in_ready`  out  1: converter can accept a word.
- `in_mode`  in  1: 0 = BCD→XS3, 1 = XS3→BCD; sampled on accept.
- `in_data`  in  4*DIGITS: packed digits, digit 0 in `[3:0]`.
- `out_valid`  out  1: result word available.
- `out_ready`  in  1: consumer takes result.
- `out_data`  out  4*DIGITS: converted digits, same packing as `in_data`.
- `out_err`  out  DIGITS: bit i set means input digit i was invalid.
- `out_mode`  out  1: mode the result was produced with.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE: `in_ready`=1. If `in_valid`, on the clock edge:
  - latch `in_data` and `in_mode`;
  - clear the digit index to 0;
  - go to CONV.
- CONV: `in_ready`=0. Each cycle converts digit[idx], writes the result nibble and error bit, and increments idx. After the digit at idx = DIGITS-1, go to DONE.
- DONE: `out_valid`=1; `out_data`, `out_err` and `out_mode` are stable. When `out_ready`=1, go to IDLE on that edge.
- Mode 0 (BCD→XS3): valid inputs are 0–9. Output = digit+3, computed mod 16 in 4 bits.
- Mode 1 (XS3→BCD): valid inputs are 3–12. Output = digit−3.
- Invalid digit: output nibble = 4'hF and the matching `out_err` bit = 1. Other digits convert normally.
- The result and error registers are cleared at the start of every accept. No stale digits carry over.
- No overlap: a new word cannot be accepted until the current result has been taken.
- Reset (sync, any state): next state IDLE.
  - Registers cleared: `out_data`=0, `out_err`=0, `out_mode`=0, idx=0.
  - While `rst`=1: `in_ready`=0 and `out_valid`=0.
  - An in-flight word is discarded and never presented.

## Timing
- Accept handshake completes at edge k (`in_valid`&`in_ready`). CONV occupies the cycles after edges k … k+DIGITS−1.
- `out_valid` rises after edge k+DIGITS. Latency is DIGITS+1 cycles from the accept cycle to the first `out_valid` cycle.
- Output handshake completes at edge m (`out_valid`&`out_ready`). `in_ready`=1 in the cycle after edge m.
- Minimum period between accepts is DIGITS+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only. They have no combinational path from `in_valid` or `out_ready`.
- `out_ready` high before DONE has no effect.
- `in_valid` outside IDLE is ignored. The producer must hold its word until accepted.
- `out_*` hold constant for the whole time DONE is backpressured.
- DIGITS=1: exactly one CONV cycle. The idx counter width is clog2(DIGITS), minimum 1 bit. Wrap of idx is never observed.
- First cycle after `rst` deasserts: state IDLE, `in_ready`=1.

## Test plan
- DIGITS=4, mode 0, `in_data`=0x1234, `out_ready`=1 → `out_data`=0x4567, `out_err`=0000, `out_mode`=0; `out_valid` rises 5 cycles after the accept cycle and lasts 1 cycle.
- Mode 1, `in_data`=0x4567 → `out_data`=0x1234, `out_err`=0000, `out_mode`=1. Also mode 0, 0x9999 → 0xCCCC.
- Mode 0, `in_data`=0x9A05 → `out_data`=0xCF38, `out_err`=0100. Mode 1, `in_data`=0x3C2D → `out_data`=0x09FF, `out_err`=0011.
- Hold `out_ready`=0 for 6 cycles in DONE with `in_valid`=1 and new data → outputs frozen, `in_ready`=0, new word not accepted. Raise `out_ready` → accepted on the 2nd cycle after the output handshake.
- Assert `rst` for 1 cycle during CONV (idx=2) → next cycle IDLE with `in_ready`=1 and all outputs 0. `out_valid` never rises for the aborted word, and a following 0x0000 mode 0 converts to 0x3333.
- DIGITS=1 build: 0x7 mode 0 → 0xA with latency 2; 0x2 mode 1 → 0xF with `out_err`=1.
